// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped
//   Direct-mapped, write-through, no-write-allocate data cache for the memory
//   stage. Read hits return data combinationally in the same cycle. A read
//   miss refills the whole line one word per backing-memory beat. Every store
//   is written through to backing memory, and the line is updated only if it
//   already hits.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   mem_read, mem_write    load / store in the memory stage (store wins if both)
//   mem_ctrl               funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i, data_i         byte address, right-aligned store data
//   data_o                 extended load result (0 when no load is completing)
//   stall                  hold F/D/E/M this cycle
//   bm_*                   word-wide req/ack backing-memory port
//   dbg_state              current FSM state (0 IDLE, 1 REFILL, 2 WRITE, 3 RESP)
//
// Handshake: a backing-memory beat completes on any cycle where bm_req and
// bm_ack are both high. bm_ack may arrive in the same cycle bm_req rises.
// bm_req, bm_addr and bm_wdata stay stable until that cycle. bm_ack is
// ignored whenever bm_req is low.
module dcache_direct_mapped #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_ctrl,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  stall,
  output logic                  bm_req,
  output logic                  bm_we,
  output logic [ADDR_WIDTH-1:0] bm_addr,
  output logic [DATA_WIDTH-1:0] bm_wdata,
  output logic [3:0]            bm_wstrb,
  input  logic [DATA_WIDTH-1:0] bm_rdata,
  input  logic                  bm_ack,
  output logic [1:0]            dbg_state
);

  localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_BITS = $clog2(SETS);
  localparam int IDX_LSB    = 2 + WORD_BITS;
  localparam int TAG_LSB    = IDX_LSB + INDEX_BITS;
  localparam int TAG_BITS   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] data_arr [SETS*WORDS_PER_LINE];
  logic [TAG_BITS-1:0]   tag_arr  [SETS];
  logic [SETS-1:0]       valid_q;
  logic [WORD_BITS-1:0]  beat_q, beat_d;

  logic [WORD_BITS-1:0]  a_word;
  logic [INDEX_BITS-1:0] a_index;
  logic [TAG_BITS-1:0]   a_tag;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line_word;

  assign a_word    = addr_i[IDX_LSB-1:2];
  assign a_index   = addr_i[TAG_LSB-1:IDX_LSB];
  assign a_tag     = addr_i[ADDR_WIDTH-1:TAG_LSB];
  assign hit       = valid_q[a_index] && (tag_arr[a_index] == a_tag);
  assign line_word = data_arr[{a_index, a_word}];
  assign dbg_state = state_q;

  // Load lane select and sign/zero extension. Unlisted codes act as W.
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_word;

  always_comb begin
    load_byte = '0;
    load_half = '0;
    load_word = '0;
    case (addr_i[1:0])
      2'd0:    load_byte = line_word[7:0];
      2'd1:    load_byte = line_word[15:8];
      2'd2:    load_byte = line_word[23:16];
      default: load_byte = line_word[31:24];
    endcase
    load_half = addr_i[1] ? line_word[31:16] : line_word[15:0];
    case (mem_ctrl)
      3'b000:  load_word = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_word = {{16{load_half[15]}}, load_half};
      3'b100:  load_word = {24'd0, load_byte};
      3'b101:  load_word = {16'd0, load_half};
      default: load_word = line_word;
    endcase
  end

  // Store data is replicated across lanes so the strobes alone pick the bytes.
  // The unsigned codes only make sense for loads, so here they size like B/H.
  logic [DATA_WIDTH-1:0] store_wdata;
  logic [3:0]            store_wstrb;
  logic [DATA_WIDTH-1:0] merged_word;

  always_comb begin
    store_wdata = data_i;
    store_wstrb = 4'hF;
    case (mem_ctrl)
      3'b000, 3'b100: begin
        store_wdata = {4{data_i[7:0]}};
        store_wstrb = 4'b0001 << addr_i[1:0];
      end
      3'b001, 3'b101: begin
        store_wdata = {2{data_i[15:0]}};
        store_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = data_i;
        store_wstrb = 4'hF;
      end
    endcase
    merged_word = line_word;
    for (int i = 0; i < 4; i++) begin
      if (store_wstrb[i]) merged_word[8*i +: 8] = store_wdata[8*i +: 8];
    end
  end

  // FSM next state and outputs
  logic load_active;
  logic refill_last;
  logic store_merge;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    stall       = 1'b0;
    bm_req      = 1'b0;
    bm_we       = 1'b0;
    bm_addr     = '0;
    bm_wdata    = '0;
    bm_wstrb    = 4'b0000;
    load_active = 1'b0;
    refill_last = 1'b0;
    store_merge = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          stall   = 1'b1;
          state_d = S_WRITE;
        end else if (mem_read) begin
          if (hit) begin
            load_active = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        stall   = 1'b1;
        bm_req  = 1'b1;
        bm_addr = {a_tag, a_index, beat_q, 2'b00};
        if (bm_ack) begin
          if (beat_q == WORD_BITS'(WORDS_PER_LINE - 1)) begin
            refill_last = 1'b1;
            beat_d      = '0;
            state_d     = S_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        stall    = 1'b1;
        bm_req   = 1'b1;
        bm_we    = 1'b1;
        bm_addr  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        bm_wdata = store_wdata;
        bm_wstrb = store_wstrb;
        if (bm_ack) begin
          store_merge = hit;
          state_d     = S_RESP;
        end
      end
      default: begin
        // S_RESP: one non-stalled cycle so the pipeline advances; the line
        // just refilled (or the store just completed) is now visible.
        load_active = mem_read && !mem_write;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign data_o = load_active ? load_word : '0;

  // Control state: reset abandons any refill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (refill_last) valid_q[a_index] <= 1'b1;
    end
  end

  // Data and tag storage are not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && bm_ack) begin
      data_arr[{a_index, beat_q}] <= bm_rdata;
    end else if (store_merge) begin
      data_arr[{a_index, a_word}] <= merged_word;
    end
    if (refill_last) tag_arr[a_index] <= a_tag;
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
module tb_dcache_direct_mapped;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_ctrl = 3'b010;
  logic [11:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        stall;
  logic        bm_req;
  logic        bm_we;
  logic [11:0] bm_addr;
  logic [31:0] bm_wdata;
  logic [3:0]  bm_wstrb;
  logic [31:0] bm_rdata = '0;
  logic        bm_ack = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  dcache_direct_mapped dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_ctrl  (mem_ctrl),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .stall     (stall),
    .bm_req    (bm_req),
    .bm_we     (bm_we),
    .bm_addr   (bm_addr),
    .bm_wdata  (bm_wdata),
    .bm_wstrb  (bm_wstrb),
    .bm_rdata  (bm_rdata),
    .bm_ack    (bm_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          phase;
    logic [2:0]  ctrl;
    logic [11:0] addr;
    logic [31:0] exp_data;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int ph, input logic [2:0] c, input logic [11:0] a,
                         input logic [31:0] d, input logic s);
    vec_t v;
    v.phase = ph; v.ctrl = c; v.addr = a; v.exp_data = d; v.exp_stall = s;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle load probes: a hit must answer in the same cycle; a miss
  // is only observed (stall high) and withdrawn before the clock edge.
  task automatic run_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        mem_read = 1'b1; mem_write = 1'b0;
        mem_ctrl = vecs[i].ctrl; addr_i = vecs[i].addr;
        #1;
        check($sformatf("p%0d_v%0d_stall", ph, i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
        if (!vecs[i].exp_stall)
          check($sformatf("p%0d_v%0d_data", ph, i), data_o, vecs[i].exp_data);
        check($sformatf("p%0d_v%0d_bm_req", ph, i), {31'd0, bm_req}, 32'd0);
        mem_read = 1'b0;
        #1;
      end
    end
  endtask

  task automatic load_miss(input logic [11:0] a, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input logic [31:0] exp_resp);
    logic [31:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    mem_read = 1'b1; mem_write = 1'b0; mem_ctrl = 3'b010; addr_i = a;
    #1;
    check("miss_stall", {31'd0, stall}, 32'd1);
    tick();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({a[11:4], 4'(b * 4)});
      check("refill_req", {31'd0, bm_req}, 32'd1);
      check("refill_we", {31'd0, bm_we}, 32'd0);
      check("refill_stall", {31'd0, stall}, 32'd1);
      check("refill_addr", {20'd0, bm_addr}, {20'd0, exp_q.pop_front()});
      bm_rdata = words[b];
      bm_ack = 1'b1;
      tick();
    end
    bm_ack = 1'b0;
    #1;
    check("resp_stall", {31'd0, stall}, 32'd0);
    check("resp_data", data_o, exp_resp);
    check("resp_req", {31'd0, bm_req}, 32'd0);
    tick();
    mem_read = 1'b0;
    #1;
  endtask

  task automatic store(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    mem_write = 1'b1; mem_read = 1'b0; mem_ctrl = c; addr_i = a; data_i = d;
    #1;
    check("store_stall", {31'd0, stall}, 32'd1);
    tick();
    check("store_req", {31'd0, bm_req}, 32'd1);
    check("store_we", {31'd0, bm_we}, 32'd1);
    check("store_addr", {20'd0, bm_addr}, {20'd0, a[11:2], 2'b00});
    check("store_wdata", bm_wdata, exp_wdata);
    check("store_wstrb", {28'd0, bm_wstrb}, {28'd0, exp_wstrb});
    bm_ack = 1'b1;
    tick();
    bm_ack = 1'b0;
    #1;
    check("store_resp_stall", {31'd0, stall}, 32'd0);
    check("store_resp_req", {31'd0, bm_req}, 32'd0);
    tick();
    mem_write = 1'b0;
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    // Phase 1: hits in the freshly refilled line 0x040 = {0x11,0x22,0x33,0x44}
    add_vec(1, 3'b010, 12'h048, 32'h00000033, 1'b0);
    add_vec(1, 3'b010, 12'h04C, 32'h00000044, 1'b0);
    add_vec(1, 3'b001, 12'h044, 32'h00000022, 1'b0);
    add_vec(1, 3'b000, 12'h04B, 32'h00000000, 1'b0);
    // Phase 2: word 0x040 = 0x000080FF
    add_vec(2, 3'b000, 12'h040, 32'hFFFFFFFF, 1'b0);
    add_vec(2, 3'b100, 12'h040, 32'h000000FF, 1'b0);
    add_vec(2, 3'b001, 12'h040, 32'hFFFF80FF, 1'b0);
    add_vec(2, 3'b101, 12'h042, 32'h00000000, 1'b0);
    add_vec(2, 3'b000, 12'h041, 32'hFFFFFF80, 1'b0);
    add_vec(2, 3'b100, 12'h041, 32'h00000080, 1'b0);
    add_vec(2, 3'b001, 12'h042, 32'h00000000, 1'b0);
    add_vec(2, 3'b011, 12'h043, 32'h000080FF, 1'b0);
    // Phase 3: after SB 0x041=0xAB and SH 0x046=0x1234
    add_vec(3, 3'b010, 12'h040, 32'h0000ABFF, 1'b0);
    add_vec(3, 3'b010, 12'h044, 32'h12340022, 1'b0);
    add_vec(3, 3'b101, 12'h046, 32'h00001234, 1'b0);
    // Phase 4: after a store miss to 0x840 (same index, tag 8)
    add_vec(4, 3'b010, 12'h840, 32'h00000000, 1'b1);
    add_vec(4, 3'b010, 12'h040, 32'h0000ABFF, 1'b0);
    // Phase 5: after the conflicting refill of 0x140
    add_vec(5, 3'b010, 12'h140, 32'h000000A0, 1'b0);
    add_vec(5, 3'b010, 12'h14C, 32'h000000A3, 1'b0);
    add_vec(5, 3'b010, 12'h040, 32'h00000000, 1'b1);

    // Reset state
    tick();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_bm_req", {31'd0, bm_req}, 32'd0);
    check("rst_bm_we", {31'd0, bm_we}, 32'd0);
    check("rst_bm_wstrb", {28'd0, bm_wstrb}, 32'd0);
    check("rst_data_o", data_o, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: cold miss and refill
    load_miss(12'h040, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);
    // 2: hits
    run_phase(1);
    // 3: store word then byte/half loads with extension
    store(3'b010, 12'h040, 32'h000080FF, 32'h000080FF, 4'b1111);
    run_phase(2);
    // 4: sub-word stores on hits, then store miss without allocation
    store(3'b000, 12'h041, 32'h000000AB, 32'hABABABAB, 4'b0010);
    store(3'b001, 12'h046, 32'h00001234, 32'h12341234, 4'b1100);
    run_phase(3);
    store(3'b010, 12'h840, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
    run_phase(4);
    // 5: conflict replaces the line
    load_miss(12'h140, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0);
    run_phase(5);

    // 6: reset after two refill beats
    mem_read = 1'b1; mem_ctrl = 3'b010; addr_i = 12'h040;
    #1;
    tick();
    for (int b = 0; b < 2; b++) begin
      bm_rdata = 32'hBAD0 + b;
      bm_ack = 1'b1;
      tick();
    end
    bm_ack = 1'b0;
    mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_bm_req", {31'd0, bm_req}, 32'd0);
    check("midrst_data_o", data_o, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // LW 0x040 misses again; memory withholds ack for 5 cycles
    mem_read = 1'b1; mem_ctrl = 3'b010; addr_i = 12'h040;
    #1;
    check("postrst_miss_stall", {31'd0, stall}, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_req", k), {31'd0, bm_req}, 32'd1);
      check($sformatf("hold%0d_addr", k), {20'd0, bm_addr}, 32'h040);
      check($sformatf("hold%0d_stall", k), {31'd0, stall}, 32'd1);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(12'h040 + 12'(b * 4));
      check("post_refill_addr", {20'd0, bm_addr}, {20'd0, exp_q.pop_front()});
      bm_rdata = 32'h55 + 32'(b * 17);
      bm_ack = 1'b1;
      tick();
    end
    bm_ack = 1'b0;
    #1;
    check("post_resp_stall", {31'd0, stall}, 32'd0);
    check("post_resp_data", data_o, 32'h00000055);
    tick();
    mem_read = 1'b0;
    #1;
    // beat 3 = 0x55 + 51 = 0x88
    add_vec(6, 3'b010, 12'h04C, 32'h00000088, 1'b0);
    run_phase(6);

    // ---------------- final report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
